// File: rtl/uart_rx_byte_fifo_if.sv
// uart_rx_byte_fifo_if
//   Byte stream between the UART receive FIFO and the command-execute stage.
//   Handshake: byte_fifo_valid=1 means byte_fifo_data holds the current head
//   byte. A byte is consumed on a clk edge where byte_fifo_rd_en=1 and
//   byte_fifo_valid=1. A rd_en seen while valid=0 is ignored. data stays stable
//   while valid=1 and no pop happens.
//   Signals:
//     byte_fifo_valid  FIFO -> consumer  head byte present
//     byte_fifo_data   FIFO -> consumer  head byte (first-word fall-through)
//     byte_fifo_rd_en  consumer -> FIFO  pop request
interface uart_rx_byte_fifo_if;
   logic       byte_fifo_valid;
   logic [7:0] byte_fifo_data;
   logic       byte_fifo_rd_en;

   modport master (output byte_fifo_valid, output byte_fifo_data, input byte_fifo_rd_en);
   modport slave  (input byte_fifo_valid, input byte_fifo_data, output byte_fifo_rd_en);
endinterface

// File: rtl/uart_rx_byte_fifo.sv
// uart_rx_byte_fifo
//   Oversampled 8N1 UART receiver feeding a first-word-fall-through byte FIFO.
//   Ports:
//     clk         clock
//     rst         synchronous reset, active low
//     uart_rx     asynchronous serial input, idle high
//     fifo_if     byte stream to the consumer (master side)
//     fifo_count  bytes currently stored, 0..DEPTH
//     frame_err   one-cycle pulse when a stop bit is sampled low
//     overflow    sticky: a received byte was dropped on a full FIFO
//     fsm_state   current receiver state, for debug and checkers
module uart_rx_byte_fifo #(
   parameter int CLKS_PER_BIT = 868,
   parameter int DEPTH        = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       uart_rx,
   uart_rx_byte_fifo_if.master        fifo_if,
   output logic [$clog2(DEPTH):0]     fifo_count,
   output logic                       frame_err,
   output logic                       overflow,
   output logic [2:0]                 fsm_state
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_F = PTR_W + 1;

   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_F-1:0] DEPTH_C   = CNT_F'(DEPTH);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      START    = 3'd1,
      DATA     = 3'd2,
      STOP     = 3'd3,
      BRK_WAIT = 3'd4
   } state_t;

   // Receiver registers
   logic             rx_meta, rx_s;
   state_t           state, state_nxt;
   logic [CNT_W-1:0] clk_cnt, clk_cnt_nxt;
   logic [2:0]       bit_idx, bit_idx_nxt;
   logic [7:0]       shreg, shreg_nxt;
   logic             push, frame_err_nxt;

   // FIFO registers
   logic [7:0]       mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr, wr_ptr;
   logic [CNT_F-1:0] count;
   logic             pop, push_ok;

   // Two-flop synchronizer; resets to the idle (high) line level.
   always_ff @(posedge clk) begin
      if (!rst) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= uart_rx;
         rx_s    <= rx_meta;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= IDLE;
         clk_cnt   <= '0;
         bit_idx   <= '0;
         shreg     <= '0;
         frame_err <= 1'b0;
      end else begin
         state     <= state_nxt;
         clk_cnt   <= clk_cnt_nxt;
         bit_idx   <= bit_idx_nxt;
         shreg     <= shreg_nxt;
         frame_err <= frame_err_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      clk_cnt_nxt   = clk_cnt + 1'b1;
      bit_idx_nxt   = bit_idx;
      shreg_nxt     = shreg;
      push          = 1'b0;
      frame_err_nxt = 1'b0;
      case (state)
         IDLE: begin
            clk_cnt_nxt = '0;
            if (!rx_s) state_nxt = START;
         end
         START: begin
            // Mid start bit: a high line here was a glitch, drop it silently.
            if (clk_cnt == HALF_LAST) begin
               clk_cnt_nxt = '0;
               bit_idx_nxt = '0;
               state_nxt   = rx_s ? IDLE : DATA;
            end
         end
         DATA: begin
            if (clk_cnt == BIT_LAST) begin
               clk_cnt_nxt = '0;
               shreg_nxt   = {rx_s, shreg[7:1]};
               if (bit_idx == 3'd7) state_nxt = STOP;
               else                 bit_idx_nxt = bit_idx + 1'b1;
            end
         end
         STOP: begin
            if (clk_cnt == BIT_LAST) begin
               clk_cnt_nxt = '0;
               if (rx_s) begin
                  push      = 1'b1;
                  state_nxt = IDLE;
               end else begin
                  frame_err_nxt = 1'b1;
                  state_nxt     = BRK_WAIT;
               end
            end
         end
         BRK_WAIT: begin
            // Hold off until the line returns high so a break yields no frames.
            clk_cnt_nxt = '0;
            if (rx_s) state_nxt = IDLE;
         end
         default: begin
            clk_cnt_nxt = '0;
            state_nxt   = IDLE;
         end
      endcase
   end

   // FIFO: a push into a full FIFO is still taken when a pop frees a slot
   // on the same edge.
   assign pop     = fifo_if.byte_fifo_rd_en & fifo_if.byte_fifo_valid;
   assign push_ok = push & ((count < DEPTH_C) | pop);

   always_ff @(posedge clk) begin
      if (!rst) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (push_ok) begin
            mem[wr_ptr] <= shreg;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         if (push_ok && !pop)      count <= count + 1'b1;
         else if (pop && !push_ok) count <= count - 1'b1;
         if (push && !push_ok) overflow <= 1'b1;
      end
   end

   assign fifo_if.byte_fifo_valid = (count != '0);
   assign fifo_if.byte_fifo_data  = mem[rd_ptr];
   assign fifo_count              = count;
   assign fsm_state               = state;

endmodule

// File: tb/tb_uart_rx_byte_fifo.sv
module tb_uart_rx_byte_fifo;
  localparam int CPB   = 16;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       uart_rx = 1'b1;
  logic [2:0] fifo_count;
  logic       frame_err;
  logic       overflow;
  logic [2:0] fsm_state;

  uart_rx_byte_fifo_if bus ();

  uart_rx_byte_fifo #(.CLKS_PER_BIT(CPB), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .uart_rx    (uart_rx),
    .fifo_if    (bus),
    .fifo_count (fifo_count),
    .frame_err  (frame_err),
    .overflow   (overflow),
    .fsm_state  (fsm_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int fe_cnt = 0;
  logic [7:0] exp_q[$];

  always @(negedge clk) if (frame_err === 1'b1) fe_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    uart_rx = 1'b1;
    bus.byte_fifo_rd_en = 1'b0;
    wait_clk(3);
    rst = 1'b1;
    exp_q.delete();
    wait_clk(2);
  endtask

  // Drives one 8N1 frame. keep: byte expected to be stored.
  // pop_at_stop: pop the head on the very edge the stop bit is sampled.
  task automatic send_frame(input logic [7:0] b, input logic stop, input bit keep,
                            input bit pop_at_stop);
    logic [7:0] h;
    if (keep) exp_q.push_back(b);
    uart_rx = 1'b0;
    wait_clk(CPB);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      wait_clk(CPB);
    end
    uart_rx = stop;
    if (pop_at_stop) begin
      wait_clk(10);
      h = exp_q.pop_front();
      check("head_at_stop", {24'd0, bus.byte_fifo_data}, {24'd0, h});
      bus.byte_fifo_rd_en = 1'b1;
      wait_clk(1);
      bus.byte_fifo_rd_en = 1'b0;
      wait_clk(CPB - 11);
    end else begin
      wait_clk(CPB);
    end
    uart_rx = 1'b1;
  endtask

  // Scoreboard pop: head must match the oldest expected byte.
  task automatic pop_check(input string tag);
    logic [7:0] e;
    check({tag, "_valid"}, {31'd0, bus.byte_fifo_valid}, 32'd1);
    if (exp_q.size() == 0) begin
      check({tag, "_exp_q_empty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_data"}, {24'd0, bus.byte_fifo_data}, {24'd0, e});
    end
    bus.byte_fifo_rd_en = 1'b1;
    wait_clk(1);
    bus.byte_fifo_rd_en = 1'b0;
  endtask

  initial begin
    int fe0;
    bus.byte_fifo_rd_en = 1'b0;
    wait_clk(3);
    check("rst_valid", {31'd0, bus.byte_fifo_valid}, 32'd0);
    check("rst_data", {24'd0, bus.byte_fifo_data}, 32'd0);
    check("rst_count", {29'd0, fifo_count}, 32'd0);
    check("rst_frame_err", {31'd0, frame_err}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    check("rst_state", {29'd0, fsm_state}, 32'd0);
    rst = 1'b1;
    wait_clk(4);

    // 1: single byte
    send_frame(8'hA5, 1'b1, 1'b1, 1'b0);
    wait_clk(2);
    check("t1_count", {29'd0, fifo_count}, 32'd1);
    pop_check("t1_pop");
    check("t1_valid_after", {31'd0, bus.byte_fifo_valid}, 32'd0);
    check("t1_count_after", {29'd0, fifo_count}, 32'd0);

    // 2: overflow, fifth byte dropped
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, i <= DEPTH, 1'b0);
    wait_clk(2);
    check("t2_count", {29'd0, fifo_count}, 32'd4);
    check("t2_overflow", {31'd0, overflow}, 32'd1);
    for (int i = 0; i < DEPTH; i++) pop_check("t2_pop");
    check("t2_empty", {31'd0, bus.byte_fifo_valid}, 32'd0);
    check("t2_overflow_sticky", {31'd0, overflow}, 32'd1);

    // 3: framing error followed by a held-low line
    fe0 = fe_cnt;
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    uart_rx = 1'b0;
    wait_clk(40);
    check("t3_brk_state", {29'd0, fsm_state}, 32'd4);
    uart_rx = 1'b1;
    wait_clk(40);
    check("t3_fe_pulses", fe_cnt - fe0, 32'd1);
    check("t3_count", {29'd0, fifo_count}, 32'd0);
    check("t3_idle", {29'd0, fsm_state}, 32'd0);
    send_frame(8'h7E, 1'b1, 1'b1, 1'b0);
    wait_clk(2);
    check("t3_count_7e", {29'd0, fifo_count}, 32'd1);
    pop_check("t3_pop");

    // 4: short glitch on the idle line
    fe0 = fe_cnt;
    uart_rx = 1'b0;
    wait_clk(5);
    uart_rx = 1'b1;
    wait_clk(30);
    check("t4_count", {29'd0, fifo_count}, 32'd0);
    check("t4_fe", fe_cnt - fe0, 32'd0);
    check("t4_idle", {29'd0, fsm_state}, 32'd0);

    // 5: full FIFO, pop on the stop-sample edge accepts the fifth byte
    do_reset();
    for (int i = 0; i < DEPTH; i++) send_frame(8'($urandom_range(0, 255)), 1'b1, 1'b1, 1'b0);
    wait_clk(2);
    check("t5_full", {29'd0, fifo_count}, 32'd4);
    send_frame(8'hC3, 1'b1, 1'b1, 1'b1);
    wait_clk(2);
    check("t5_count", {29'd0, fifo_count}, 32'd4);
    check("t5_overflow", {31'd0, overflow}, 32'd0);
    for (int i = 0; i < DEPTH; i++) pop_check("t5_pop");
    check("t5_empty", {29'd0, fifo_count}, 32'd0);

    // 6: reset mid-frame, then a clean byte
    uart_rx = 1'b0;
    wait_clk(CPB);
    for (int i = 0; i < 4; i++) begin
      uart_rx = i[0];
      wait_clk(CPB);
    end
    wait_clk(CPB / 2);
    rst = 1'b0;
    uart_rx = 1'b1;
    wait_clk(3);
    rst = 1'b1;
    exp_q.delete();
    wait_clk(2 * CPB);
    check("t6_rst_count", {29'd0, fifo_count}, 32'd0);
    send_frame(8'h5A, 1'b1, 1'b1, 1'b0);
    wait_clk(2);
    check("t6_count", {29'd0, fifo_count}, 32'd1);
    pop_check("t6_pop");
    for (int i = 0; i < 3; i++) begin
      bus.byte_fifo_rd_en = 1'b1;
      wait_clk(1);
      bus.byte_fifo_rd_en = 1'b0;
      wait_clk(1);
    end
    check("t6_underflow_count", {29'd0, fifo_count}, 32'd0);
    check("t6_underflow_valid", {31'd0, bus.byte_fifo_valid}, 32'd0);
    check("t6_exp_q_drained", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
